// File: rtl/psram_cmd_scheduler.sv
// Round-robin command scheduler in front of a PSRAM controller: enforces command
// spacing, tags reads by master and routes returning beats. Option: SCHED_RD_WATCHDOG_EN.
module psram_cmd_scheduler #(
  parameter int NUM_MASTERS = 3,
  parameter int CMD_GAP     = 14,
  parameter int RD_BEATS    = 4,
  parameter int TAG_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_MASTERS-1:0]       m_req,
  input  logic [NUM_MASTERS-1:0]       m_cmd,
  input  logic [NUM_MASTERS-1:0][20:0] m_addr,
  input  logic [NUM_MASTERS-1:0][63:0] m_wr_data,
  input  logic [NUM_MASTERS-1:0][7:0]  m_data_mask,
  output logic [NUM_MASTERS-1:0]       m_gnt,
  output logic [63:0]                  m_rd_data,
  output logic [NUM_MASTERS-1:0]       m_rd_valid,
  output logic                         mem_cmd_en,
  output logic                         mem_cmd,
  output logic [20:0]                  mem_addr,
  output logic [63:0]                  mem_wr_data,
  output logic [7:0]                   mem_data_mask,
  input  logic [63:0]                  mem_rd_data,
  input  logic                         mem_rd_data_valid,
  input  logic                         mem_calib,
  output logic                         err
);

  localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W  = $clog2(TAG_DEPTH + 1);
  localparam int BEAT_W = (RD_BEATS > 1) ? $clog2(RD_BEATS) : 1;
  localparam int GAP_W  = 6;

  logic [GAP_W-1:0]       r_gap;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [IDX_W-1:0]       r_tag_mem [TAG_DEPTH];
  logic [TAG_AW-1:0]      r_wptr;
  logic [TAG_AW-1:0]      r_rptr;
  logic [CNT_W-1:0]       r_count;
  logic [BEAT_W-1:0]      r_beat;
  logic [NUM_MASTERS-1:0] r_gnt;
  logic                   r_cmd_en;
  logic                   r_cmd;
  logic [20:0]            r_addr;
  logic [63:0]            r_wr_data;
  logic [7:0]             r_mask;
  logic [63:0]            r_rd_data;
  logic [NUM_MASTERS-1:0] r_rd_valid;
  logic                   r_err;

  logic [NUM_MASTERS-1:0] w_elig;
  logic                   w_full;
  logic                   w_found;
  logic [IDX_W-1:0]       w_winner;
  logic [IDX_W:0]         w_cand;
  logic [IDX_W-1:0]       w_next_ptr;
  logic                   w_issue;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_beat_ok;
  logic                   w_beat_last;
  logic [IDX_W-1:0]       w_head;
  logic                   w_wd_fire;

  function automatic logic [TAG_AW-1:0] f_ptr_inc(input logic [TAG_AW-1:0] p);
    return (p == TAG_AW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full = (r_count == CNT_W'(TAG_DEPTH));

  // Reads only compete while a tag slot is free; writes are always eligible.
  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_elig
      assign w_elig[gi] = m_req[gi] & (m_cmd[gi] | ~w_full);
    end
  endgenerate

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_cand = (IDX_W+1)'(r_rr_ptr) + (IDX_W+1)'(i);
      if (w_cand >= (IDX_W+1)'(NUM_MASTERS))
        w_cand = w_cand - (IDX_W+1)'(NUM_MASTERS);
      if (!w_found && w_elig[w_cand[IDX_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[IDX_W-1:0];
      end
    end
  end

  assign w_next_ptr  = (w_winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : w_winner + 1'b1;
  assign w_issue     = mem_calib & (r_gap == '0) & w_found;
  assign w_push      = w_issue & ~m_cmd[w_winner];
  assign w_head      = r_tag_mem[r_rptr];
  assign w_beat_ok   = mem_rd_data_valid & (r_count != '0);
  assign w_beat_last = (r_beat == BEAT_W'(RD_BEATS - 1));
  assign w_pop       = (w_beat_ok & w_beat_last) | w_wd_fire;

`ifdef SCHED_RD_WATCHDOG_EN
  logic [9:0] r_wd;

  // Any beat proves the controller is alive; an empty tag FIFO has nothing to wait for.
  always_ff @(posedge clk) begin
    if (reset)
      r_wd <= '0;
    else if (mem_rd_data_valid || r_count == '0 || r_wd == 10'd1023)
      r_wd <= '0;
    else
      r_wd <= r_wd + 10'd1;
  end

  assign w_wd_fire = (r_wd == 10'd1023) & ~mem_rd_data_valid & (r_count != '0);
`else
  assign w_wd_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_push)
      r_tag_mem[r_wptr] <= w_winner;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gap      <= '0;
      r_rr_ptr   <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_beat     <= '0;
      r_gnt      <= '0;
      r_cmd_en   <= 1'b0;
      r_cmd      <= 1'b0;
      r_addr     <= '0;
      r_wr_data  <= '0;
      r_mask     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= '0;
      r_err      <= 1'b0;
    end else begin
      r_gnt    <= '0;
      r_cmd_en <= 1'b0;
      // Loading CMD_GAP-1 here puts consecutive issue decisions exactly CMD_GAP apart.
      if (w_issue) begin
        r_gap           <= GAP_W'(CMD_GAP - 1);
        r_rr_ptr        <= w_next_ptr;
        r_gnt[w_winner] <= 1'b1;
        r_cmd_en        <= 1'b1;
        r_cmd           <= m_cmd[w_winner];
        r_addr          <= m_addr[w_winner];
        r_wr_data       <= m_wr_data[w_winner];
        r_mask          <= m_data_mask[w_winner];
      end else if (r_gap != '0) begin
        r_gap <= r_gap - 1'b1;
      end

      if (w_push)
        r_wptr <= f_ptr_inc(r_wptr);
      if (w_pop)
        r_rptr <= f_ptr_inc(r_rptr);
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;

      r_rd_valid <= '0;
      if (w_beat_ok) begin
        r_rd_data          <= mem_rd_data;
        r_rd_valid[w_head] <= 1'b1;
      end

      if (w_wd_fire)
        r_beat <= '0;
      else if (w_beat_ok)
        r_beat <= w_beat_last ? '0 : r_beat + 1'b1;

      if ((mem_rd_data_valid && r_count == '0) || w_wd_fire)
        r_err <= 1'b1;
    end
  end

  assign m_gnt         = r_gnt;
  assign m_rd_data     = r_rd_data;
  assign m_rd_valid    = r_rd_valid;
  assign mem_cmd_en    = r_cmd_en;
  assign mem_cmd       = r_cmd;
  assign mem_addr      = r_addr;
  assign mem_wr_data   = r_wr_data;
  assign mem_data_mask = r_mask;
  assign err           = r_err;

endmodule

// File: tb/tb_psram_cmd_scheduler.sv
// Bench for psram_cmd_scheduler: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then random traffic (SCHED_RD_WATCHDOG_EN adds a watchdog case).
`timescale 1ns/1ps
module tb_psram_cmd_scheduler;
  localparam int N = 3, GAP = 14, BEATS = 4, DEPTH = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        m_req, m_cmd;
  logic [N-1:0][20:0]  m_addr;
  logic [N-1:0][63:0]  m_wr_data;
  logic [N-1:0][7:0]   m_data_mask;
  logic [N-1:0]        m_gnt, m_rd_valid;
  logic [63:0]         m_rd_data;
  logic                mem_cmd_en, mem_cmd;
  logic [20:0]         mem_addr;
  logic [63:0]         mem_wr_data;
  logic [7:0]          mem_data_mask;
  logic [63:0]         mem_rd_data;
  logic                mem_rd_data_valid, mem_calib;
  logic                err;

  psram_cmd_scheduler #(.NUM_MASTERS(N), .CMD_GAP(GAP), .RD_BEATS(BEATS), .TAG_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_data_mask(m_data_mask), .m_gnt(m_gnt), .m_rd_data(m_rd_data),
    .m_rd_valid(m_rd_valid), .mem_cmd_en(mem_cmd_en), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_data_mask(mem_data_mask), .mem_rd_data(mem_rd_data),
    .mem_rd_data_valid(mem_rd_data_valid), .mem_calib(mem_calib), .err(err));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: tags as a queue, command spacing as "earliest allowed cycle".
  int           q_tags[$];
  int           md_beats, md_ptr, md_next_ok, md_wd, md_win, md_size;
  logic [N-1:0] e_gnt, e_rd_valid;
  logic         e_cmd_en, e_cmd, e_err;
  logic [20:0]  e_addr;
  logic [63:0]  e_wr, e_rd_data;
  logic [7:0]   e_mask;

  always @(posedge clk) begin
    cyc++;
    e_gnt = '0; e_cmd_en = 1'b0; e_rd_valid = '0;
    if (reset) begin
      q_tags.delete();
      md_beats = 0; md_ptr = 0; md_next_ok = 0; md_wd = 0;
      e_cmd = 0; e_addr = 0; e_wr = 0; e_mask = 0; e_rd_data = 0; e_err = 0;
    end else begin
      md_size = q_tags.size();
      md_win = -1;
      if (mem_calib && cyc >= md_next_ok)
        for (int k = 0; k < N; k++)
          if (md_win < 0 && m_req[(md_ptr + k) % N] && (m_cmd[(md_ptr + k) % N] || md_size < DEPTH))
            md_win = (md_ptr + k) % N;
      if (mem_rd_data_valid) begin
        md_wd = 0;
        if (md_size == 0) e_err = 1'b1;
        else begin
          e_rd_data = mem_rd_data;
          e_rd_valid[q_tags[0]] = 1'b1;
          md_beats++;
          if (md_beats == BEATS) begin
            void'(q_tags.pop_front());
            md_beats = 0;
          end
        end
      end
`ifdef SCHED_RD_WATCHDOG_EN
      else if (md_size != 0) begin
        if (md_wd == 1023) begin
          void'(q_tags.pop_front());
          md_beats = 0; e_err = 1'b1; md_wd = 0;
        end else md_wd++;
      end else md_wd = 0;
`endif
      if (md_win >= 0) begin
        e_cmd_en = 1'b1;
        e_gnt[md_win] = 1'b1;
        e_cmd = m_cmd[md_win]; e_addr = m_addr[md_win];
        e_wr = m_wr_data[md_win]; e_mask = m_data_mask[md_win];
        md_next_ok = cyc + GAP;
        md_ptr = (md_win + 1) % N;
        if (!m_cmd[md_win]) q_tags.push_back(md_win);
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("m_gnt", 64'(m_gnt), 64'(e_gnt));
      chk("mem_cmd_en", 64'(mem_cmd_en), 64'(e_cmd_en));
      chk("mem_cmd", 64'(mem_cmd), 64'(e_cmd));
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("mem_wr_data", mem_wr_data, e_wr);
      chk("mem_data_mask", 64'(mem_data_mask), 64'(e_mask));
      chk("m_rd_valid", 64'(m_rd_valid), 64'(e_rd_valid));
      chk("m_rd_data", m_rd_data, e_rd_data);
      chk("err", 64'(err), 64'(e_err));
    end
  end

  task automatic step();
    @(negedge clk);
    for (int m = 0; m < N; m++)
      if (m_gnt[m]) m_req[m] = 1'b0;
  endtask

  task automatic request(input int m, input logic cmd, input logic [20:0] addr);
    m_cmd[m] = cmd;
    m_addr[m] = addr;
    m_wr_data[m] = {$urandom, $urandom};
    m_data_mask[m] = 8'($urandom);
    m_req[m] = 1'b1;
  endtask

  task automatic wait_gnt(input int m, input int budget, input string name, output int n);
    n = 0;
    while (!m_gnt[m] && n < budget) begin
      step();
      n++;
    end
    chk(name, 64'(m_gnt[m]), 64'd1);
  endtask

  task automatic burst();
    for (int b = 0; b < BEATS; b++) begin
      mem_rd_data = {$urandom, $urandom};
      mem_rd_data_valid = 1'b1;
      step();
    end
    mem_rd_data_valid = 1'b0;
  endtask

  int n;
  int g_cyc[$];
  int g_mst[$];
  logic seen;
  logic [63:0] dv;

  initial begin
    reset = 1'b1; mem_calib = 1'b0; mem_rd_data_valid = 1'b0; mem_rd_data = '0;
    m_req = '0; m_cmd = '0; m_addr = '0; m_wr_data = '0; m_data_mask = '0;
    step(); step();
    chk("rst_gnt", 64'(m_gnt), 64'd0);
    chk("rst_cmd_en", 64'(mem_cmd_en), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_rd_data", m_rd_data, 64'd0);
    reset = 1'b0;

    // No issue while uncalibrated, then 0,1,2 spaced by GAP
    for (int m = 0; m < N; m++) request(m, 1'b1, 21'(m));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_cmd_en) seen = 1'b1;
    end
    chk("nocalib_no_issue", 64'(seen), 64'd0);
    mem_calib = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (mem_cmd_en)
        for (int m = 0; m < N; m++)
          if (m_gnt[m]) begin g_cyc.push_back(cyc); g_mst.push_back(m); end
    end
    chk("calib_grant_count", 64'(g_cyc.size()), 64'd3);
    if (g_cyc.size() == 3) begin
      chk("order_0", 64'(g_mst[0]), 64'd0);
      chk("order_1", 64'(g_mst[1]), 64'd1);
      chk("order_2", 64'(g_mst[2]), 64'd2);
      chk("spacing_01", 64'(g_cyc[1] - g_cyc[0]), 64'd14);
      chk("spacing_12", 64'(g_cyc[2] - g_cyc[1]), 64'd14);
    end

    // Master 1 read, four beats routed one cycle later
    request(1, 1'b0, 21'h000100);
    wait_gnt(1, 40, "rd1_gnt", n);
    chk("rd1_addr", 64'(mem_addr), 64'h100);
    chk("rd1_cmd", 64'(mem_cmd), 64'd0);
    for (int b = 0; b < 4; b++) begin
      dv = 64'hD0D0_0000_0000_0000 | 64'(b);
      mem_rd_data = dv;
      mem_rd_data_valid = 1'b1;
      step();
      chk("rd1_valid", 64'(m_rd_valid), 64'b010);
      chk("rd1_data", m_rd_data, dv);
    end
    mem_rd_data_valid = 1'b0;
    step();
    chk("rd1_valid_done", 64'(m_rd_valid), 64'd0);

    // Fill the tag FIFO, write still passes, 5th read waits for a pop
    request(0, 1'b0, 21'h10); wait_gnt(0, 40, "fill_0", n);
    request(1, 1'b0, 21'h11); wait_gnt(1, 40, "fill_1", n);
    request(2, 1'b0, 21'h12); wait_gnt(2, 40, "fill_2", n);
    request(0, 1'b0, 21'h13); wait_gnt(0, 40, "fill_3", n);
    request(2, 1'b1, 21'h20); wait_gnt(2, 40, "full_write_gnt", n);
    request(1, 1'b0, 21'h14);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin step(); if (m_gnt[1]) seen = 1'b1; end
    for (int b = 0; b < 4; b++) begin
      mem_rd_data = {$urandom, $urandom};
      mem_rd_data_valid = 1'b1;
      step();
      if (m_gnt[1]) seen = 1'b1;
    end
    mem_rd_data_valid = 1'b0;
    chk("full_read_held", 64'(seen), 64'd0);
    wait_gnt(1, 10, "full_read_after_pop", n);
    chk("full_read_latency", 64'(n), 64'd1);
    for (int t = 0; t < 4; t++) burst();
    step();

    // Beat with empty FIFO is dropped and flags err
    chk("pre_drop_err", 64'(err), 64'd0);
    mem_rd_data = 64'hDEAD_BEEF_0000_0001;
    mem_rd_data_valid = 1'b1;
    step();
    mem_rd_data_valid = 1'b0;
    chk("drop_valid", 64'(m_rd_valid), 64'd0);
    chk("drop_err", 64'(err), 64'd1);

    // Reset mid-gap: next request granted right after reset
    request(0, 1'b1, 21'h30); wait_gnt(0, 40, "pre_rst_gnt", n);
    for (int i = 0; i < 5; i++) step();
    request(1, 1'b1, 21'h31);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("post_rst_gnt", 64'(m_gnt), 64'b010);
    chk("post_rst_err", 64'(err), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      mem_calib = ($urandom % 16) != 0;
      reset = ($urandom % 400) == 0;
      mem_rd_data_valid = ($urandom % 5) == 0;
      mem_rd_data = {$urandom, $urandom};
      for (int m = 0; m < N; m++)
        if (!m_req[m] && ($urandom % 4) == 0) request(m, 1'(($urandom % 2)), 21'($urandom));
    end
    m_req = '0; mem_rd_data_valid = 1'b0; mem_calib = 1'b1;
    reset = 1'b1; step(); step(); reset = 1'b0;

`ifdef SCHED_RD_WATCHDOG_EN
    // Reads never return: watchdog frees a tag and flags err
    request(0, 1'b0, 21'h40); wait_gnt(0, 40, "wd_fill_0", n);
    request(1, 1'b0, 21'h41); wait_gnt(1, 40, "wd_fill_1", n);
    request(2, 1'b0, 21'h42); wait_gnt(2, 40, "wd_fill_2", n);
    request(0, 1'b0, 21'h43); wait_gnt(0, 40, "wd_fill_3", n);
    chk("wd_err_before", 64'(err), 64'd0);
    request(1, 1'b0, 21'h44);
    wait_gnt(1, 1200, "wd_freed_gnt", n);
    chk("wd_wait_long", 64'(n > 900), 64'd1);
    chk("wd_err", 64'(err), 64'd1);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
